// File: rtl/op_sequencer.sv
// op_sequencer: three-state instruction sequencer driving an external
// registered ALU and owning an 8 x n register file (r0 reads as zero).
//
// Handshake: an instruction is transferred on a rising edge where both
// instr_valid and instr_ready are high. instr_ready is high only in IDLE
// and never while Reset is high. instr_valid may be held high; it is
// ignored until the sequencer returns to IDLE.
module op_sequencer #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic [n-1:0] DataA,
  output logic [n-1:0] DataB,
  output logic         WriteEn,
  output logic         UseMul,
  input  logic [n-1:0] alu_result,
  output logic         done,
  input  logic [2:0]   dbg_addr,
  output logic [n-1:0] dbg_data
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [n-1:0]  regs_q [8];

  logic [1:0]    op;
  logic [2:0]    rd, rs, rt;
  logic [n-1:0]  imm;
  logic          wr_en;
  logic [n-1:0]  wr_data;

  assign op  = instr_q[15:14];
  assign rd  = instr_q[13:11];
  assign rs  = instr_q[10:8];
  assign rt  = instr_q[7:5];
  assign imm = instr_q[n-1:0];

  // r0 is never written, but the read is forced to zero regardless.
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

  // Next-state and output decode; everything is held at zero while Reset
  // is high so an abandoned instruction neither writes back nor retires.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_ready = 1'b0;
    DataA       = '0;
    DataB       = '0;
    WriteEn     = 1'b0;
    UseMul      = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    if (!Reset) begin
      case (state_q)
        S_IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            state_d = S_ISSUE;
            instr_d = instr;
          end
        end
        S_ISSUE: begin
          // Operands are read here, before the CAPT writeback, so rd==rs/rt
          // sees the old register value.
          DataA   = regs_q[rs];
          DataB   = regs_q[rt];
          WriteEn = (op == OP_ADD) || (op == OP_MUL);
          UseMul  = (op == OP_MUL);
          state_d = S_CAPT;
        end
        S_CAPT: begin
          done    = 1'b1;
          state_d = S_IDLE;
          wr_en   = (op != OP_NOP) && (rd != 3'd0);
          wr_data = (op == OP_LDI) ? imm : alu_result;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, captured instruction and register file; reset clears all.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      if (wr_en) regs_q[rd] <= wr_data;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: registered ALU model, architectural register model,
// directed scenarios plus randomized instruction streams.
module tb_op_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         Reset;
  logic         instr_valid;
  logic         instr_ready;
  logic [15:0]  instr;
  logic [N-1:0] DataA, DataB;
  logic         WriteEn, UseMul;
  logic [N-1:0] alu_result;
  logic         done;
  logic [2:0]   dbg_addr;
  logic [N-1:0] dbg_data;

  int checks = 0;
  int failures = 0;

  // architectural register model
  logic [N-1:0] m [8];

  // activity counters and accept log (pre-edge values)
  int cyc = 0;
  int we_cnt = 0;
  int mul_cnt = 0;
  int done_cnt = 0;
  int acc_q[$];

  op_sequencer #(.n(N)) dut (
    .clk(clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .DataA(DataA), .DataB(DataB), .WriteEn(WriteEn), .UseMul(UseMul),
    .alu_result(alu_result), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // clock
  always #5 clk = ~clk;

  // registered ALU, one cycle latency, n-bit wrap
  always @(posedge clk) begin
    alu_result <= UseMul ? (DataA * DataB) : (DataA + DataB);
  end

  // monitor
  always @(posedge clk) begin
    cyc++;
    if (WriteEn) we_cnt++;
    if (UseMul) mul_cnt++;
    if (done) done_cnt++;
    if (instr_valid && instr_ready) acc_q.push_back(cyc);
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 5'b0};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b10, rd, 3'b000, imm};
  endfunction

  // architectural effect of one instruction
  function automatic void apply(input logic [15:0] w);
    logic [31:0] t;
    logic [2:0] rd;
    rd = w[13:11];
    case (w[15:14])
      2'b00: t = 32'(m[w[10:8]]) + 32'(m[w[7:5]]);
      2'b01: t = 32'(m[w[10:8]]) * 32'(m[w[7:5]]);
      2'b10: t = 32'(w[7:0]);
      default: t = 32'(m[rd]);
    endcase
    if (rd != 3'd0) m[rd] = t[N-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m[i] = '0;
  endtask

  // one full instruction with per-phase checks
  task automatic run_instr(input logic [15:0] w);
    logic [1:0] op;
    logic [2:0] rd;
    logic [N-1:0] ea, eb;
    int we0, mul0, done0;
    bit got;
    op = w[15:14];
    rd = w[13:11];
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    we0 = we_cnt; mul0 = mul_cnt; done0 = done_cnt;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (instr_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout: instr=%h instr_ready never rose", w);
      instr_valid = 1'b0;
      return;
    end
    ea = m[w[10:8]];
    eb = m[w[7:5]];
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (DataA !== ea || DataB !== eb || WriteEn !== (op < 2) || UseMul !== (op == 1) ||
        instr_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL issue_phase instr=%h: A=%h B=%h we=%b mul=%b rdy=%b done=%b, expected A=%h B=%h we=%b mul=%b rdy=0 done=0",
               w, DataA, DataB, WriteEn, UseMul, instr_ready, done, ea, eb, op < 2, op == 1);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || WriteEn !== 1'b0 || UseMul !== 1'b0 || DataA !== '0 ||
        DataB !== '0 || instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL capt_phase instr=%h: done=%b we=%b mul=%b A=%h B=%h rdy=%b, expected done=1 others 0",
               w, done, WriteEn, UseMul, DataA, DataB, instr_ready);
    end
    apply(w);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_return instr=%h: done=%b rdy=%b, expected done=0 rdy=1", w, done, instr_ready);
    end
    dbg_addr = rd; #1;
    checks++;
    if (dbg_data !== m[rd]) begin
      failures++;
      $display("FAIL writeback instr=%h r%0d: got %h expected %h", w, rd, dbg_data, m[rd]);
    end
    checks++;
    if (we_cnt - we0 != int'(op < 2) || mul_cnt - mul0 != int'(op == 1) || done_cnt - done0 != 1) begin
      failures++;
      $display("FAIL pulse_counts instr=%h: we=%0d mul=%0d done=%0d expected we=%0d mul=%0d done=1",
               w, we_cnt - we0, mul_cnt - mul0, done_cnt - done0, int'(op < 2), int'(op == 1));
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || WriteEn !== 1'b0 || UseMul !== 1'b0 || DataA !== '0 || DataB !== '0) begin
      failures++;
      $display("FAIL reset_outputs: done=%b we=%b mul=%b A=%h B=%h, expected all 0",
               done, WriteEn, UseMul, DataA, DataB);
    end
    Reset = 1'b0; #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: rdy=%b expected 1", instr_ready);
    end
    model_clear();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== '0) begin
        failures++;
        $display("FAIL reset_regs r%0d: got %h expected 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_add();
    run_instr(ldi(3'd1, 8'd5));
    run_instr(ldi(3'd2, 8'd7));
    run_instr(enc(2'b00, 3'd3, 3'd1, 3'd2));
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 8'd12) begin
      failures++;
      $display("FAIL add_r3: got %h expected 0c", dbg_data);
    end
  endtask

  task automatic test_mul();
    run_instr(ldi(3'd1, 8'd3));
    run_instr(ldi(3'd2, 8'd4));
    run_instr(enc(2'b01, 3'd4, 3'd1, 3'd2));
    dbg_addr = 3'd4; #1;
    checks++;
    if (dbg_data !== 8'd12) begin
      failures++;
      $display("FAIL mul_r4: got %h expected 0c", dbg_data);
    end
  endtask

  task automatic test_r0_and_wrap();
    run_instr(ldi(3'd0, 8'hFF));
    dbg_addr = 3'd0; #1;
    checks++;
    if (dbg_data !== '0) begin
      failures++;
      $display("FAIL r0_zero: got %h expected 0", dbg_data);
    end
    run_instr(ldi(3'd5, 8'h81));
    run_instr(enc(2'b00, 3'd5, 3'd5, 3'd5));
    dbg_addr = 3'd5; #1;
    checks++;
    if (dbg_data !== 8'h02) begin
      failures++;
      $display("FAIL add_wrap_r5: got %h expected 02", dbg_data);
    end
  endtask

  task automatic test_nop();
    logic [N-1:0] snap [8];
    for (int i = 0; i < 8; i++) snap[i] = m[i];
    run_instr(enc(2'b11, 3'd3, 3'd1, 3'd2));
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== snap[i]) begin
        failures++;
        $display("FAIL nop_regs r%0d: got %h expected %h", i, dbg_data, snap[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [4];
    int k;
    bit ok;
    w[0] = ldi(3'd1, 8'($urandom_range(1, 255)));
    w[1] = ldi(3'd2, 8'($urandom_range(1, 255)));
    w[2] = enc(2'b00, 3'd3, 3'd1, 3'd2);
    w[3] = enc(2'b01, 3'd4, 3'd1, 3'd2);
    ok = 1'b1;
    @(negedge clk);
    acc_q.delete();
    instr = w[0];
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (acc_q.size() <= i && k < 12) begin
        @(posedge clk); #1;
        k++;
      end
      checks++;
      if (acc_q.size() <= i) begin
        failures++;
        $display("FAIL b2b_accept_timeout: instruction %0d never accepted", i);
        ok = 1'b0;
        break;
      end
      apply(w[i]);
      if (i < 3) instr = w[i+1];
      else instr_valid = 1'b0;
      checks++;
      if (instr_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ready_issue %0d: rdy=%b expected 0", i, instr_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (instr_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ready_capt %0d: rdy=%b expected 0", i, instr_ready);
      end
    end
    instr_valid = 1'b0;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_q[i+1] - acc_q[i] != 3) begin
          failures++;
          $display("FAIL b2b_spacing %0d: got %0d cycles expected 3", i, acc_q[i+1] - acc_q[i]);
        end
      end
    end
    @(posedge clk); @(posedge clk); #1;
    for (int r = 1; r <= 4; r++) begin
      dbg_addr = 3'(r); #1;
      checks++;
      if (dbg_data !== m[r]) begin
        failures++;
        $display("FAIL b2b_regs r%0d: got %h expected %h", r, dbg_data, m[r]);
      end
    end
  endtask

  task automatic test_reset_in_capt();
    int done0;
    run_instr(ldi(3'd1, 8'd9));
    run_instr(ldi(3'd2, 8'd11));
    done0 = done_cnt;
    @(negedge clk);
    instr = enc(2'b00, 3'd6, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0 || WriteEn !== 1'b1) begin
      failures++;
      $display("FAIL rst_capt_issue: rdy=%b we=%b expected rdy=0 we=1", instr_ready, WriteEn);
    end
    @(posedge clk); #1;
    Reset = 1'b1; #1;
    checks++;
    if (done !== 1'b0 || WriteEn !== 1'b0 || DataA !== '0 || DataB !== '0 || UseMul !== 1'b0) begin
      failures++;
      $display("FAIL rst_capt_outputs: done=%b we=%b mul=%b A=%h B=%h expected all 0",
               done, WriteEn, UseMul, DataA, DataB);
    end
    @(posedge clk); #1;
    Reset = 1'b0; #1;
    model_clear();
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_capt_ready: rdy=%b expected 1", instr_ready);
    end
    checks++;
    if (done_cnt != done0) begin
      failures++;
      $display("FAIL rst_capt_done: %0d done pulses expected 0", done_cnt - done0);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== '0) begin
        failures++;
        $display("FAIL rst_capt_regs r%0d: got %h expected 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_reset_priority();
    int done0;
    done0 = done_cnt;
    @(negedge clk);
    Reset = 1'b1;
    instr = ldi(3'd7, 8'h55);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || WriteEn !== 1'b0) begin
      failures++;
      $display("FAIL rst_prio_state: rdy=%b we=%b expected rdy=1 we=0", instr_ready, WriteEn);
    end
    repeat (3) @(posedge clk);
    #1;
    dbg_addr = 3'd7; #1;
    checks++;
    if (done_cnt != done0 || dbg_data !== '0) begin
      failures++;
      $display("FAIL rst_prio_effect: done pulses=%0d r7=%h expected 0 and 00", done_cnt - done0, dbg_data);
    end
    model_clear();
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 30; i++) begin
      w = 16'($urandom);
      // bias toward loads early so arithmetic sees nonzero operands
      if (i < 6) w = ldi(3'($urandom_range(1, 7)), 8'($urandom));
      run_instr(w);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_r0_and_wrap();
    test_nop();
    test_back_to_back();
    test_reset_in_capt();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
